// File: rtl/divider.sv
// Sequential unsigned divider using restoring shift-subtract, one quotient bit per clock.
//
// Ports:
//   Clock        - system clock, rising-edge active
//   nReset       - asynchronous active-low reset
//   Start        - request a division (sampled in IDLE or DONE)
//   Number0      - dividend, captured on an accepted Start
//   Number1      - divisor, captured on an accepted Start
//   Busy         - high while the iteration sequence runs
//   Done         - one-cycle pulse when results are valid
//   DivByZero    - high when the captured divisor was zero
//   outputNumber - quotient (all ones on divide-by-zero)
//   Remainder    - remainder (dividend on divide-by-zero)
module divider #(
  parameter int unsigned WIDTH = 21
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Number0,
  input  logic [WIDTH-1:0] Number1,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] outputNumber,
  output logic [WIDTH-1:0] Remainder
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  // Dividend register; quotient bits shift in at the LSB as dividend bits leave the MSB,
  // so after WIDTH steps it holds the quotient.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_sub;
  logic             q_bit;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // One restoring step. The shifted partial remainder needs WIDTH+1 bits: it can reach
  // 2*divisor-1, which overflows WIDTH bits when the divisor MSB is set.
  always_comb begin
    r_shift = {rem_q, dvd_q[WIDTH-1]};
    r_sub   = r_shift - {1'b0, dvs_q};
    q_bit   = (r_shift >= {1'b0, dvs_q});
    // Either branch is below the divisor, so the top bit is always zero here.
    r_next  = q_bit ? r_sub[WIDTH-1:0] : r_shift[WIDTH-1:0];
    q_next  = {dvd_q[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      DivByZero    <= 1'b0;
      outputNumber <= '0;
      Remainder    <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (Start) begin
            if (Number1 != '0) begin
              dvd_q   <= Number0;
              dvs_q   <= Number1;
              rem_q   <= '0;
              cnt_q   <= CW'(WIDTH - 1);
              Busy    <= 1'b1;
              state_q <= StRun;
            end else begin
              // Zero divisor skips the iterations and reports immediately.
              DivByZero    <= 1'b1;
              outputNumber <= '1;
              Remainder    <= Number0;
              Done         <= 1'b1;
              state_q      <= StDone;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          dvd_q <= q_next;
          rem_q <= r_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            outputNumber <= q_next;
            Remainder    <= r_next;
            DivByZero    <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b1;
            state_q      <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
module tb_divider;

  localparam int W = 21;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] n0;
  logic [W-1:0] n1;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] q;
  logic [W-1:0] r;

  int checks = 0;
  int errors = 0;

  divider #(.WIDTH(W)) dut (
    .Clock       (clk),
    .nReset      (rst_n),
    .Start       (start),
    .Number0     (n0),
    .Number1     (n1),
    .Busy        (busy),
    .Done        (done),
    .DivByZero   (dz),
    .outputNumber(q),
    .Remainder   (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    int           elat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Launch one division and follow it to its Done pulse; edges are counted from the
  // accepting edge, sampling 1 ns after each rising edge.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input int elat);
    int lat;
    int busy_cnt;
    int hold_bad;
    bit seen;
    logic [W-1:0] pq;
    logic [W-1:0] pr;
    logic         pdz;
    @(negedge clk);
    pq = q; pr = r; pdz = dz;
    start = 1'b1; n0 = a; n1 = b;
    @(posedge clk); #1;
    start = 1'b0;
    n0 = ~a; n1 = ~b;  // captured operands must not follow the buses
    lat = 0; busy_cnt = 0; hold_bad = 0; seen = 0;
    while (!seen && lat <= 40) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) busy_cnt++;
        if (q !== pq || r !== pr || dz !== pdz) hold_bad++;
        @(posedge clk); #1;
        lat++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", lat, elat);
    chk("quotient", 32'(q), 32'(eq));
    chk("remainder", 32'(r), 32'(er));
    chk("divbyzero", 32'(dz), 32'(edz));
    chk("busy_cycles", busy_cnt, (elat == 0) ? 0 : W);
    chk("hold_during_run", hold_bad, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int ndone;
    int lat1, lat2;
    logic [W-1:0] q1, r1, q2, r2;
    bit early_done;

    vecs.push_back('{21'd100,     21'd7,        21'd14,       21'd2,        1'b0, 21});
    vecs.push_back('{21'h1FFFFF,  21'd1,        21'h1FFFFF,   21'd0,        1'b0, 21});
    vecs.push_back('{21'h1FFFFF,  21'h100000,   21'd1,        21'h0FFFFF,   1'b0, 21});
    vecs.push_back('{21'd5,       21'd9,        21'd0,        21'd5,        1'b0, 21});
    vecs.push_back('{21'd0,       21'd3,        21'd0,        21'd0,        1'b0, 21});
    vecs.push_back('{21'd42,      21'd0,        21'h1FFFFF,   21'd42,       1'b1, 0});
    vecs.push_back('{21'h100000,  21'h1FFFFF,   21'd0,        21'h100000,   1'b0, 21});
    vecs.push_back('{21'h1FFFFF,  21'h1FFFFF,   21'd1,        21'd0,        1'b0, 21});
    vecs.push_back('{21'h1FFFFE,  21'h1FFFFF,   21'd0,        21'h1FFFFE,   1'b0, 21});
    vecs.push_back('{21'd1000,    21'd3,        21'd333,      21'd1,        1'b0, 21});
    vecs.push_back('{21'd123456,  21'd789,      21'd156,      21'd372,      1'b0, 21});
    vecs.push_back('{21'd7,       21'd0,        21'h1FFFFF,   21'd7,        1'b1, 0});

    rst_n = 1'b0; start = 1'b0; n0 = '0; n1 = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_div(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edz, vecs[i].elat);
    end

    // Start held high; operands swapped mid-run, second op launched from DONE.
    @(negedge clk);
    start = 1'b1; n0 = 21'd1000; n1 = 21'd10;
    @(posedge clk); #1;
    ndone = 0; lat1 = -1; lat2 = -1;
    q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    for (int i = 1; i <= 60 && ndone < 2; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin
        n0 = 21'd77; n1 = 21'd5;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          lat1 = i; q1 = q; r1 = r;
        end else begin
          lat2 = i; q2 = q; r2 = r;
          start = 1'b0;
        end
      end
    end
    chk("b2b_ndone", ndone, 2);
    chk("b2b_lat1", lat1, W);
    chk("b2b_q1", 32'(q1), 32'd100);
    chk("b2b_r1", 32'(r1), 32'd0);
    chk("b2b_lat2", lat2, 2 * W + 1);
    chk("b2b_q2", 32'(q2), 32'd15);
    chk("b2b_r2", 32'(r2), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("b2b_no_extra_done", ndone, 2);
    chk("b2b_idle_busy", 32'(busy), 32'd0);

    // Leave DivByZero set, then abort a run with reset.
    do_div(21'd42, 21'd0, 21'h1FFFFF, 21'd42, 1'b1, 0);
    @(negedge clk);
    start = 1'b1; n0 = 21'd1000; n1 = 21'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dz", 32'(dz), 32'd0);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_r", 32'(r), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    early_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done || busy) early_done = 1;
    end
    chk("abort_no_done", 32'(early_done), 32'd0);
    do_div(21'd9, 21'd4, 21'd2, 21'd1, 1'b0, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
